// File: rtl/sr_input_conditioner.sv
// Conditions two raw request lines (set/clear) into mutually exclusive,
// single-cycle s/r pulses for a downstream SR flip-flop.

module sr_input_conditioner_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic lvl,
  output logic evt
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      cnt   <= '0;
      evt   <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      evt   <= 1'b0;
      // Any return to the accepted level (a bounce) restarts the count.
      if (sync2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl <= sync2;
        cnt <= '0;
        evt <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

module sr_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int CONFLICT_MODE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_btn,
  input  logic clr_btn,
  output logic s,
  output logic r,
  output logic conflict,
  output logic set_level,
  output logic clr_level
);

  localparam logic SET_WINS = (CONFLICT_MODE == 1);
  localparam logic CLR_WINS = (CONFLICT_MODE == 2);

  logic set_evt;
  logic clr_evt;

  sr_input_conditioner_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (set_btn),
    .lvl    (set_level),
    .evt    (set_evt)
  );

  sr_input_conditioner_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (clr_btn),
    .lvl    (clr_level),
    .evt    (clr_evt)
  );

  // Arbitration: at most one of s/r can win, so the flip-flop never sees s=r=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= set_evt & (~clr_evt | SET_WINS);
      r        <= clr_evt & (~set_evt | CLR_WINS);
      conflict <= set_evt & clr_evt;
    end
  end

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Directed bench for sr_input_conditioner: one instance per conflict mode,
// all sharing the same clock, reset and button stimulus.

module tb_sr_input_conditioner;

  logic clk;
  logic reset_n;
  logic set_btn;
  logic clr_btn;
  logic s0, r0, c0, sl0, cl0;
  logic s1, r1, c1, sl1, cl1;
  logic s2, r2, c2, sl2, cl2;

  int chk_cnt;
  int pass_cnt;

  sr_input_conditioner #(.CONFLICT_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s0), .r(r0), .conflict(c0), .set_level(sl0), .clr_level(cl0));
  sr_input_conditioner #(.CONFLICT_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s1), .r(r1), .conflict(c1), .set_level(sl1), .clr_level(cl1));
  sr_input_conditioner #(.CONFLICT_MODE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .set_btn(set_btn), .clr_btn(clr_btn),
    .s(s2), .r(r2), .conflict(c2), .set_level(sl2), .clr_level(cl2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    assert (!(s0 && r0) && !(s1 && r1) && !(s2 && r2))
      else $error("s and r high together");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    set_btn = 1'b0;
    clr_btn = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    logic exp;
    reset_n = 1'b0;
    set_btn = 1'b1;
    clr_btn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_cnt++;
      if ({s0, r0, c0, sl0, cl0} !== 5'b0)
        $display("FAIL reset_outs k=%0d got %b required 00000", k, {s0, r0, c0, sl0, cl0});
      else pass_cnt++;
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k == 7);
      chk_cnt++;
      if (s0 !== exp) $display("FAIL reset_release_s k=%0d got %b required %b", k, s0, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_press();
    logic exp_s, exp_l;
    set_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_s = (k == 7);
      exp_l = (k >= 6);
      chk_cnt++;
      if (s0 !== exp_s) $display("FAIL clean_s k=%0d got %b required %b", k, s0, exp_s);
      else pass_cnt++;
      chk_cnt++;
      if (sl0 !== exp_l) $display("FAIL clean_level k=%0d got %b required %b", k, sl0, exp_l);
      else pass_cnt++;
      chk_cnt++;
      if ({r0, c0} !== 2'b00) $display("FAIL clean_r_conf k=%0d got %b required 00", k, {r0, c0});
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    logic exp;
    pat = 6'b011011;  // applied LSB first: 1,1,0,1,1,0
    for (int k = 0; k < 6; k++) begin
      clr_btn = pat[k];
      tick();
      chk_cnt++;
      if (r0 !== 1'b0) $display("FAIL bounce_quiet k=%0d got %b required 0", k, r0);
      else pass_cnt++;
    end
    clr_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (k == 7);
      chk_cnt++;
      if (r0 !== exp) $display("FAIL bounce_r k=%0d got %b required %b", k, r0, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp;
    set_btn = 1'b1;
    clr_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      // {mode0 s,r,c | mode1 s,r,c | mode2 s,r,c}
      exp = (k == 7) ? 9'b001_101_011 : 9'b000_000_000;
      chk_cnt++;
      if ({s0, r0, c0, s1, r1, c1, s2, r2, c2} !== exp)
        $display("FAIL simul k=%0d got %b required %b", k,
                 {s0, r0, c0, s1, r1, c1, s2, r2, c2}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_staggered();
    logic es, er;
    set_btn = 1'b1;
    tick();
    clr_btn = 1'b1;
    for (int k = 2; k <= 14; k++) begin
      tick();
      es = (k == 7);
      er = (k == 8);
      chk_cnt++;
      if ({s0, r0, c0} !== {es, er, 1'b0})
        $display("FAIL stagger k=%0d got %b required %b", k, {s0, r0, c0}, {es, er, 1'b0});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic exp;
    set_btn = 1'b1;
    repeat (5) tick();
    chk_cnt++;
    if (dut0.u_set.cnt !== 8'd3) $display("FAIL mid_cnt_before got %0d required 3", dut0.u_set.cnt);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (dut0.u_set.cnt !== 8'd0) $display("FAIL mid_cnt_reset got %0d required 0", dut0.u_set.cnt);
    else pass_cnt++;
    chk_cnt++;
    if ({s0, sl0, dut0.u_set.sync1, dut0.u_set.sync2} !== 4'b0)
      $display("FAIL mid_regs_reset got %b required 0000", {s0, sl0, dut0.u_set.sync1, dut0.u_set.sync2});
    else pass_cnt++;
    repeat (3) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k == 7);
      chk_cnt++;
      if (s0 !== exp) $display("FAIL mid_release_s k=%0d got %b required %b", k, s0, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_pulse_lost();
    set_btn = 1'b1;
    repeat (7) tick();
    chk_cnt++;
    if (s0 !== 1'b1) $display("FAIL lost_pulse_seen got %b required 1", s0);
    else pass_cnt++;
    reset_n = 1'b0;
    set_btn = 1'b0;
    #1;
    chk_cnt++;
    if (s0 !== 1'b0) $display("FAIL lost_pulse_cleared got %b required 0", s0);
    else pass_cnt++;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_cnt++;
      if (s0 !== 1'b0) $display("FAIL lost_no_replay k=%0d got %b required 0", k, s0);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      set_btn = 1'($urandom_range(0, 1));
      clr_btn = 1'($urandom_range(0, 1));
      if ((k % 16) > 9) begin
        set_btn = 1'b1;
        clr_btn = 1'b1;
      end
      tick();
      chk_cnt++;
      if ((s0 & r0) | (s1 & r1) | (s2 & r2))
        $display("FAIL random_excl k=%0d got %b%b%b required 000", k, s0 & r0, s1 & r1, s2 & r2);
      else pass_cnt++;
    end
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    reset_n  = 1'b0;
    set_btn  = 1'b0;
    clr_btn  = 1'b0;
    test_reset();
    go_idle();
    test_clean_press();
    go_idle();
    test_bounce();
    go_idle();
    test_simultaneous();
    go_idle();
    test_staggered();
    go_idle();
    test_reset_mid();
    go_idle();
    test_pulse_lost();
    go_idle();
    test_random();
    go_idle();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Upstream conditioning stage for the SR flip-flop. It takes two raw, asynchronous, possibly bouncing request lines (set and clear). It synchronizes and debounces each one, detects press events, and arbitrates between them. It then drives single-cycle, mutually exclusive `s`/`r` pulses straight into the flip-flop's `s`/`r` inputs, so the flip-flop never sees the invalid s=1, r=1 combination.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before it is accepted. Legal range 1 to 2^CNT_W−1.
- `CNT_W`, default 8: width of each debounce counter.
- `CONFLICT_MODE`, default 0: same-cycle set/clear events are handled as follows.
  - 0: drop both.
  - 1: set wins.
  - 2: clear wins.
- `clk` input 1: single clock. All logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset. Asserting it clears every flop immediately. Deassertion is synchronous to `clk` at system level.
- `set_btn` input 1: raw asynchronous set request.
- `clr_btn` input 1: raw asynchronous clear request.
- `s` output 1: registered one-cycle set pulse to the flip-flop.
- `r` output 1: registered one-cycle reset pulse to the flip-flop.
- `conflict` output 1: registered one-cycle flag, asserted when set and clear events coincide.
- `set_level` output 1: debounced, registered level of `set_btn`.
- `clr_level` output 1: debounced, registered level of `clr_btn`.

## Operation
- Two identical channels (set and clear), then a shared arbiter.
- Each channel has a 2-flop synchronizer, `sync1` → `sync2`, which gives the synchronized level `sync`.
- Debounce, per channel, with registered level `lvl` and counter `cnt`:
  - If `sync == lvl`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES−1`: `lvl` ← `sync`, `cnt` ← 0, and the registered event flag `evt` ← 1 when the new level is 1.
  - Else: `cnt` ← `cnt`+1.
  - `evt` is 0 in every other cycle.
- A bounce, meaning `sync` returns to `lvl` before the count completes, clears `cnt`. Counting then restarts from 0.
- Only rising transitions of `lvl` (presses) create events. Releases create no output pulse.
- Arbiter, registered, evaluated each cycle from `set_evt` and `clr_evt`:
  - Only `set_evt`: `s`=1, `r`=0, `conflict`=0.
  - Only `clr_evt`: `s`=0, `r`=1, `conflict`=0.
  - Both, with CONFLICT_MODE 0: `s`=0, `r`=0, `conflict`=1.
  - Both, with CONFLICT_MODE 1: `s`=1, `r`=0, `conflict`=1.
  - Both, with CONFLICT_MODE 2: `s`=0, `r`=1, `conflict`=1.
  - Neither: all three outputs are 0.
- Invariant: `s` and `r` are never 1 in the same cycle.
- Each accepted press yields exactly one pulse. Holding a button produces no repeated pulses.

## Timing
- Reset values: every synchronizer flop, `cnt`, `lvl`, `evt`, `s`, `r`, `conflict`, `set_level` and `clr_level` are 0. All of these are forced to 0 asynchronously while `reset_n`=0, including mid-debounce and mid-pulse.
- A pulse in flight when reset asserts is lost. It is not replayed after release.
- Latency from clean input to pulse (no bounce): take the first edge that samples `set_btn`=1 as edge 1.
  - `sync` is 1 after edge 2.
  - `set_level` and `set_evt` are 1 after edge 2+DEBOUNCE_CYCLES.
  - `s` is 1 after edge 3+DEBOUNCE_CYCLES, for exactly one cycle.
  - With the default DEBOUNCE_CYCLES=4, `s` goes high after edge 7.
- Release latency is the same: `set_level` returns to 0 after edge 2+DEBOUNCE_CYCLES from the first sampled 0.
- Coincidence is judged only on same-cycle `evt` flags. Events one cycle apart are not a conflict and produce back-to-back `s` then `r` pulses (or the reverse).
- Button held through reset release: the debounce restarts from `lvl`=0. The held button produces one pulse DEBOUNCE_CYCLES+3 edges after release.
- DEBOUNCE_CYCLES=1: a level is accepted on the first cycle `sync` differs from `lvl`.

## Test plan
- Reset behaviour: drive `reset_n`=0 while `set_btn`=1.
  - All outputs stay 0.
  - After release, exactly one `s` pulse arrives 7 edges later, with defaults.
- Clean press: raise `set_btn` and hold it for 20 cycles.
  - `s`=1 for one cycle, 7 edges after the first sample.
  - `set_level`=1 from edge 6 onward.
  - `r`=0 and `conflict`=0 throughout.
- Bounce rejection: toggle `clr_btn` 1,1,0,1,1,0 per cycle, then hold it at 1.
  - No `r` pulse during the toggling.
  - Exactly one `r` pulse, 7 edges after the start of the steady 1s.
- Simultaneous press: raise `set_btn` and `clr_btn` on the same cycle, once for each CONFLICT_MODE.
  - Mode 0: `s`=0, `r`=0, `conflict`=1.
  - Mode 1: `s`=1, `r`=0, `conflict`=1.
  - Mode 2: `s`=0, `r`=1, `conflict`=1.
- Staggered press: raise `clr_btn` one cycle after `set_btn`.
  - `s` pulse followed on the next cycle by an `r` pulse.
  - `conflict` stays 0.
- Reset mid-operation: assert `reset_n`=0 three cycles into the debounce count of `set_btn`.
  - `cnt` and `s` are 0 immediately.
  - After release with the button still held, one `s` pulse arrives 7 edges later.
  - A random-stimulus assertion checks that `s`&`r` is never 1.
